// File: rtl/match_pkg.sv
// Shared types and constants for the matching-point sampler.
// The offsets mirror the subtraction constants used by the matching-point calculator.
package match_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_ACC,
    ST_DONE
  } state_t;

  localparam int XOFF  = 1776;
  localparam int YOFF  = 176;
  localparam int IMG_W = 2592;
  localparam int IMG_H = 1944;

  // Signed width that holds +/- npts*(2^pix_w - 1).
  function automatic int SCORE_W(input int pix_w, input int npts);
    return pix_w + 1 + $clog2(npts);
  endfunction

endpackage

// File: rtl/match_addr_gen.sv
// Turns a window-relative point into a frame-memory address and an out-of-image flag.
module match_addr_gen #(
  parameter int WIDTH       = 14,
  parameter int LOG2_STRIDE = 12,
  parameter int XOFF        = match_pkg::XOFF,
  parameter int YOFF        = match_pkg::YOFF,
  parameter int IMG_W       = match_pkg::IMG_W,
  parameter int IMG_H       = match_pkg::IMG_H
) (
  input  logic [WIDTH-1:0]             i_x,
  input  logic [WIDTH-1:0]             i_y,
  output logic [WIDTH+LOG2_STRIDE-1:0] o_addr,
  output logic                         o_oob
);

  localparam int AW = WIDTH + LOG2_STRIDE;

  logic [WIDTH-1:0] w_x_abs;
  logic [WIDTH-1:0] w_y_abs;

  // Offsets wrap modulo 2^WIDTH, so a large relative value can land back near zero.
  always_comb begin
    w_x_abs = i_x + WIDTH'(XOFF);
    w_y_abs = i_y + WIDTH'(YOFF);
    o_addr  = {w_y_abs, {LOG2_STRIDE{1'b0}}} + AW'(w_x_abs);
    o_oob   = (w_x_abs >= WIDTH'(IMG_W)) || (w_y_abs >= WIDTH'(IMG_H));
  end

endmodule

// File: rtl/match_point_sampler.sv
// Samples one pixel per inner/outer matching point and reports sum(outer - inner).
// Strobe and address are registered on entry to REQ so the read issues in that cycle.
module match_point_sampler #(
  parameter int WIDTH       = 14,
  parameter int NPTS        = 4,
  parameter int PIX_W       = 8,
  parameter int XOFF        = match_pkg::XOFF,
  parameter int YOFF        = match_pkg::YOFF,
  parameter int IMG_W       = match_pkg::IMG_W,
  parameter int IMG_H       = match_pkg::IMG_H,
  parameter int LOG2_STRIDE = 12
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic [WIDTH*NPTS-1:0]                       new_xi,
  input  logic [WIDTH*NPTS-1:0]                       new_yi,
  input  logic [WIDTH*NPTS-1:0]                       new_xo,
  input  logic [WIDTH*NPTS-1:0]                       new_yo,
  input  logic [WIDTH-1:0]                            xb_i,
  input  logic [WIDTH-1:0]                            yb_i,
  output logic                                        mem_rd_en,
  output logic [WIDTH+LOG2_STRIDE-1:0]                mem_addr,
  input  logic                                        mem_rd_valid,
  input  logic [PIX_W-1:0]                            mem_rd_data,
  output logic                                        score_valid,
  input  logic                                        score_ready,
  output logic signed [match_pkg::SCORE_W(PIX_W, NPTS)-1:0] score,
  output logic [$clog2(2*NPTS):0]                     oob_cnt,
  output logic [WIDTH-1:0]                            xb_o,
  output logic [WIDTH-1:0]                            yb_o
);

  import match_pkg::*;

  localparam int SW = SCORE_W(PIX_W, NPTS);
  localparam int IW = $clog2(2*NPTS);
  localparam int PW = $clog2(NPTS);
  localparam int OW = IW + 1;
  localparam int AW = WIDTH + LOG2_STRIDE;

  state_t                 r_state;
  logic                   r_in_ready;
  logic                   r_rd_en;
  logic [AW-1:0]          r_addr;
  logic                   r_oob;
  logic [IW-1:0]          r_idx;
  logic [PIX_W-1:0]       r_pix;
  logic signed [SW-1:0]   r_acc;
  logic signed [SW-1:0]   r_score;
  logic                   r_score_valid;
  logic [OW-1:0]          r_oob_cnt;
  logic [WIDTH*NPTS-1:0]  r_xi;
  logic [WIDTH*NPTS-1:0]  r_yi;
  logic [WIDTH*NPTS-1:0]  r_xo;
  logic [WIDTH*NPTS-1:0]  r_yo;
  logic [WIDTH-1:0]       r_xb;
  logic [WIDTH-1:0]       r_yb;

  logic [IW-1:0]          w_nidx;
  logic [PW-1:0]          w_pt;
  logic [WIDTH*NPTS-1:0]  w_src_xi;
  logic [WIDTH*NPTS-1:0]  w_src_yi;
  logic [WIDTH*NPTS-1:0]  w_src_xo;
  logic [WIDTH*NPTS-1:0]  w_src_yo;
  logic [WIDTH-1:0]       w_x;
  logic [WIDTH-1:0]       w_y;
  logic [AW-1:0]          w_addr;
  logic                   w_oob;
  logic signed [SW-1:0]   w_pix_ext;
  logic signed [SW-1:0]   w_acc_next;

  // Point for the next REQ: sample 0 straight from the inputs when accepting, else the next index.
  always_comb begin
    w_nidx   = (r_state == ST_IDLE) ? '0 : r_idx + IW'(1);
    w_pt     = w_nidx[IW-1:1];
    w_src_xi = (r_state == ST_IDLE) ? new_xi : r_xi;
    w_src_yi = (r_state == ST_IDLE) ? new_yi : r_yi;
    w_src_xo = (r_state == ST_IDLE) ? new_xo : r_xo;
    w_src_yo = (r_state == ST_IDLE) ? new_yo : r_yo;
    if (w_nidx[0]) begin
      w_x = w_src_xo[int'(w_pt)*WIDTH +: WIDTH];
      w_y = w_src_yo[int'(w_pt)*WIDTH +: WIDTH];
    end else begin
      w_x = w_src_xi[int'(w_pt)*WIDTH +: WIDTH];
      w_y = w_src_yi[int'(w_pt)*WIDTH +: WIDTH];
    end
  end

  match_addr_gen #(
    .WIDTH       (WIDTH),
    .LOG2_STRIDE (LOG2_STRIDE),
    .XOFF        (XOFF),
    .YOFF        (YOFF),
    .IMG_W       (IMG_W),
    .IMG_H       (IMG_H)
  ) u_addr_gen (
    .i_x    (w_x),
    .i_y    (w_y),
    .o_addr (w_addr),
    .o_oob  (w_oob)
  );

  always_comb begin
    w_pix_ext  = $signed({{(SW-PIX_W){1'b0}}, r_pix});
    w_acc_next = r_idx[0] ? (r_acc + w_pix_ext) : (r_acc - w_pix_ext);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_in_ready    <= 1'b1;
      r_rd_en       <= 1'b0;
      r_addr        <= '0;
      r_oob         <= 1'b0;
      r_idx         <= '0;
      r_pix         <= '0;
      r_acc         <= '0;
      r_score       <= '0;
      r_score_valid <= 1'b0;
      r_oob_cnt     <= '0;
      r_xi          <= '0;
      r_yi          <= '0;
      r_xo          <= '0;
      r_yo          <= '0;
      r_xb          <= '0;
      r_yb          <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_xi       <= new_xi;
            r_yi       <= new_yi;
            r_xo       <= new_xo;
            r_yo       <= new_yo;
            r_xb       <= xb_i;
            r_yb       <= yb_i;
            r_idx      <= '0;
            r_acc      <= '0;
            r_oob_cnt  <= '0;
            r_in_ready <= 1'b0;
            r_oob      <= w_oob;
            r_rd_en    <= !w_oob;
            r_addr     <= w_addr;
            r_state    <= ST_REQ;
          end
        end
        // Out-of-image samples never touch memory and contribute a zero pixel.
        ST_REQ: begin
          r_rd_en <= 1'b0;
          if (r_oob) begin
            r_pix     <= '0;
            r_oob_cnt <= r_oob_cnt + OW'(1);
            r_state   <= ST_ACC;
          end else begin
            r_state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_rd_valid) begin
            r_pix   <= mem_rd_data;
            r_state <= ST_ACC;
          end
        end
        ST_ACC: begin
          r_acc <= w_acc_next;
          if (r_idx == IW'(2*NPTS-1)) begin
            r_score       <= w_acc_next;
            r_score_valid <= 1'b1;
            r_state       <= ST_DONE;
          end else begin
            r_idx   <= r_idx + IW'(1);
            r_oob   <= w_oob;
            r_rd_en <= !w_oob;
            r_addr  <= w_addr;
            r_state <= ST_REQ;
          end
        end
        ST_DONE: begin
          if (score_ready) begin
            r_score_valid <= 1'b0;
            r_in_ready    <= 1'b1;
            r_addr        <= '0;
            r_state       <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign mem_rd_en   = r_rd_en;
  assign mem_addr    = r_addr;
  assign score_valid = r_score_valid;
  assign score       = r_score;
  assign oob_cnt     = r_oob_cnt;
  assign xb_o        = r_xb;
  assign yb_o        = r_yb;

endmodule
